// File: rtl/ps2_rx_event_fifo.sv
// rtl/ps2_rx_event_fifo.sv - PS/2 device-to-host receiver with prefix decoder and event FIFO
module ps2_rx_event_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wait_for_incoming_data,
  input  logic                          start_receiving_data,
  input  logic                          ps2_clk_posedge,
  input  logic                          ps2_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_extended,
  output logic                          out_release,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          timeout_error,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = DATA_BITS + 2;
  localparam logic [DATA_BITS-1:0] CODE_EXT = DATA_BITS'(8'hE0);
  localparam logic [DATA_BITS-1:0] CODE_REL = DATA_BITS'(8'hF0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 frame_ok_d, par_err_d, frm_err_d, to_err_d;
  logic                 frame_valid_q;
  logic [DATA_BITS-1:0] frame_byte_q;
  logic                 parity_error_q, framing_error_q, timeout_error_q, overflow_q;
  logic                 ext_q, ext_d, rel_q, rel_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 in_frame, timeout_hit;
  logic                 is_ext, is_rel, push, pop, push_ok, overflow_d;
  logic [EW-1:0]        push_entry, head;

  assign in_frame    = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
  assign timeout_hit = in_frame && !ps2_clk_posedge && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_bit_d  = par_bit_q;
    to_cnt_d   = (ps2_clk_posedge || !in_frame) ? '0 : to_cnt_q + TW'(1);
    frame_ok_d = 1'b0;
    par_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    to_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (wait_for_incoming_data)    state_d = S_WAIT_START;
        else if (start_receiving_data) state_d = S_DATA;
      end
      S_WAIT_START: begin
        bit_cnt_d = '0;
        if (!wait_for_incoming_data)           state_d = S_IDLE;
        else if (ps2_clk_posedge && !ps2_data) state_d = S_DATA;
      end
      S_DATA: begin
        if (timeout_hit) begin
          state_d  = S_IDLE;
          to_err_d = 1'b1;
        end else if (ps2_clk_posedge) begin
          shift_d   = {ps2_data, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (timeout_hit) begin
          state_d  = S_IDLE;
          to_err_d = 1'b1;
        end else if (ps2_clk_posedge) begin
          par_bit_d = ps2_data;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (timeout_hit) begin
          state_d  = S_IDLE;
          to_err_d = 1'b1;
        end else if (ps2_clk_posedge) begin
          state_d = S_IDLE;
          // Odd parity: data plus parity must hold an odd number of ones.
          if (!(^{shift_q, par_bit_q})) par_err_d  = 1'b1;
          else if (!ps2_data)           frm_err_d  = 1'b1;
          else                          frame_ok_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign is_ext     = (DECODE != 0) && (frame_byte_q == CODE_EXT);
  assign is_rel     = (DECODE != 0) && (frame_byte_q == CODE_REL);
  assign push       = frame_valid_q && !is_ext && !is_rel;
  assign push_entry = {ext_q, rel_q, frame_byte_q};

  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    if (parity_error_q || framing_error_q || timeout_error_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (frame_valid_q) begin
      if (is_ext)      ext_d = 1'b1;
      else if (is_rel) rel_d = 1'b1;
      else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop        = (count_q != '0) && out_ready;
  assign push_ok    = push && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign overflow_d = push && !push_ok;
  assign count_d    = count_q + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      par_bit_q       <= 1'b0;
      to_cnt_q        <= '0;
      frame_valid_q   <= 1'b0;
      frame_byte_q    <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
      overflow_q      <= 1'b0;
      ext_q           <= 1'b0;
      rel_q           <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      par_bit_q       <= par_bit_d;
      to_cnt_q        <= to_cnt_d;
      frame_valid_q   <= frame_ok_d;
      if (frame_ok_d) frame_byte_q <= shift_q;
      parity_error_q  <= par_err_d;
      framing_error_q <= frm_err_d;
      timeout_error_q <= to_err_d;
      overflow_q      <= overflow_d;
      ext_q           <= ext_d;
      rel_q           <= rel_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q         <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_valid     = (count_q != '0);
  assign out_data      = out_valid ? head[DATA_BITS-1:0] : '0;
  assign out_release   = out_valid && head[DATA_BITS];
  assign out_extended  = out_valid && head[DATA_BITS+1];
  assign fifo_count    = count_q;
  assign busy          = (state_q != S_IDLE);
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign timeout_error = timeout_error_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// tb/tb_ps2_rx_event_fifo.sv - directed bench with a queue-based reference model of the event FIFO
module tb_ps2_rx_event_fifo;
  localparam int FD = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, wait_i, start_i, strobe, ps2_data, out_ready;
  logic out_valid, out_extended, out_release, busy;
  logic parity_error, framing_error, timeout_error, overflow;
  logic [7:0] out_data;
  logic [2:0] fifo_count;

  ps2_rx_event_fifo #(.DATA_BITS(8), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO), .DECODE(1)) dut (
    .clk(clk), .reset(reset),
    .wait_for_incoming_data(wait_i), .start_receiving_data(start_i),
    .ps2_clk_posedge(strobe), .ps2_data(ps2_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_extended(out_extended),
    .out_release(out_release), .fifo_count(fifo_count), .busy(busy),
    .parity_error(parity_error), .framing_error(framing_error),
    .timeout_error(timeout_error), .overflow(overflow)
  );

  // kind: 0 good frame, 1 parity error, 2 framing error, 3 timeout; n = stop-strobe or timeout cycle
  typedef struct { int n; int kind; logic [7:0] b; } ev_t;
  ev_t        evq[$];
  logic [9:0] mq[$];
  bit m_ext, m_rel, e_par, e_frm, e_to, e_ovf;
  int cyc = 0;
  int n_cmp = 0, n_fail = 0;
  bit armed = 0;
  int c_par = 0, c_frm = 0, c_to = 0, c_ovf = 0, c_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin : model
    bit pop, np, nf, nt, no;
    int sz;
    if (!reset) begin
      mq.delete(); evq.delete();
      m_ext = 0; m_rel = 0;
      np = 0; nf = 0; nt = 0; no = 0;
    end else begin
      np = 0; nf = 0; nt = 0; no = 0;
      sz  = mq.size();
      pop = (sz > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      foreach (evq[i]) begin
        if (evq[i].n == cyc) begin
          if (evq[i].kind == 1) np = 1;
          if (evq[i].kind == 2) nf = 1;
          if (evq[i].kind == 3) nt = 1;
        end
        if (evq[i].n == cyc - 1) begin
          if (evq[i].kind != 0) begin
            m_ext = 0; m_rel = 0;
          end else if (evq[i].b == 8'hE0) m_ext = 1;
          else if (evq[i].b == 8'hF0) m_rel = 1;
          else begin
            if (sz < FD || pop) mq.push_back({m_ext, m_rel, evq[i].b});
            else no = 1;
            m_ext = 0; m_rel = 0;
          end
        end
      end
      evq = evq.find(x) with (x.n >= cyc);
    end
    e_par = np; e_frm = nf; e_to = nt; e_ovf = no;
    cyc++;
  end

  always @(negedge clk) begin : compare
    logic [17:0] act, req;
    logic [9:0]  hd;
    if (armed) begin
      hd  = (mq.size() != 0) ? mq[0] : 10'h0;
      req = {mq.size() != 0, hd[9], hd[8], hd[7:0], 3'(mq.size()), e_par, e_frm, e_to, e_ovf};
      act = {out_valid, out_extended, out_release, out_data, fifo_count,
             parity_error, framing_error, timeout_error, overflow};
      chk("cycle_outputs", 32'(act), 32'(req));
      if (parity_error)  c_par++;
      if (framing_error) c_frm++;
      if (timeout_error) c_to++;
      if (overflow)      c_ovf++;
      if (out_valid && out_ready) c_pop++;
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic gap; repeat (3) tick; endtask

  task automatic strobe_bit(input logic d, output int n);
    ps2_data = d; strobe = 1; n = cyc;
    tick;
    strobe = 0; ps2_data = 1;
  endtask

  // Returns in the cycle after the stop strobe; n is the stop-strobe cycle.
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stopv, output int n);
    logic p; int d; int kind;
    wait_i = 1; tick;
    strobe_bit(1'b0, d); gap;
    for (int i = 0; i < 8; i++) begin strobe_bit(b[i], d); gap; end
    p = ~(^b) ^ flip;
    strobe_bit(p, d); gap;
    wait_i = 0;
    kind = (((^b) ^ p) == 1'b0) ? 1 : (!stopv ? 2 : 0);
    ps2_data = stopv; strobe = 1; n = cyc;
    evq.push_back('{n, kind, b});
    tick;
    strobe = 0; ps2_data = 1;
  endtask

  task automatic partial(input int nbits, output int s);
    int d;
    wait_i = 1; tick;
    strobe_bit(1'b0, d); gap;
    wait_i = 0;
    s = d;
    for (int i = 0; i < nbits; i++) begin strobe_bit(i[0], s); gap; end
  endtask

  initial begin
    int n, s, base;
    reset = 0; wait_i = 0; start_i = 0; strobe = 0; ps2_data = 1; out_ready = 0;
    repeat (3) tick;
    armed = 1;
    chk("reset_outputs", 32'({out_valid, fifo_count, busy, out_data, parity_error,
        framing_error, timeout_error, overflow}), 32'd0);
    reset = 1; tick;

    // single good frame, consumer always ready
    out_ready = 1;
    send_frame(8'h1C, 0, 1, n);
    chk("t1_busy_after_stop", 32'(busy), 32'd0);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    tick;
    chk("t1_head_n2", 32'({out_valid, out_extended, out_release, out_data}), 32'({3'b100, 8'h1C}));
    tick;
    chk("t1_drained", 32'({out_valid, fifo_count}), 32'd0);
    gap;

    // prefixes fold into one event
    base = c_pop;
    send_frame(8'hE0, 0, 1, n); gap;
    send_frame(8'hF0, 0, 1, n); gap;
    send_frame(8'h75, 0, 1, n); tick;
    chk("t2_head_ext_rel", 32'({out_valid, out_extended, out_release, out_data}), 32'({3'b111, 8'h75}));
    gap;
    chk("t2_one_entry", 32'(c_pop - base), 32'd1);
    send_frame(8'h75, 0, 1, n); tick;
    chk("t2_head_plain", 32'({out_valid, out_extended, out_release, out_data}), 32'({3'b100, 8'h75}));
    gap;

    // parity then framing error
    base = c_par + c_frm * 16;
    send_frame(8'h1C, 1, 1, n); gap;
    send_frame(8'h1C, 0, 0, n); gap;
    chk("t3_par_pulses", 32'(c_par - base % 16), 32'd1);
    chk("t3_frm_pulses", 32'(c_frm - base / 16), 32'd1);
    chk("t3_fifo_empty", 32'({out_valid, fifo_count}), 32'd0);

    // timeout after 3 data bits
    partial(3, s);
    chk("t4_busy_in_frame", 32'(busy), 32'd1);
    evq.push_back('{s + TO, 3, 8'h00});
    while (cyc < s + TO) tick;
    chk("t4_no_timeout_yet", 32'(timeout_error), 32'd0);
    tick;
    chk("t4_timeout_pulse", 32'({timeout_error, busy}), 32'b10);
    tick;
    send_frame(8'h29, 0, 1, n); tick;
    chk("t4_after_timeout", 32'({out_valid, out_extended, out_release, out_data}), 32'({3'b100, 8'h29}));
    gap;

    // overflow with a stalled consumer
    out_ready = 0;
    base = c_ovf;
    for (int i = 1; i <= 5; i++) begin send_frame(8'(i), 0, 1, n); gap; end
    chk("t5_count_full", 32'(fifo_count), 32'd4);
    chk("t5_overflow_once", 32'(c_ovf - base), 32'd1);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("t5_drain", 32'({out_valid, out_data}), 32'({1'b1, 8'(i)}));
      tick;
    end
    chk("t5_drained", 32'(out_valid), 32'd0);
    out_ready = 0;

    // pop coincides with the 5th push
    base = c_ovf;
    for (int i = 1; i <= 4; i++) begin send_frame(8'h10 + 8'(i), 0, 1, n); gap; end
    send_frame(8'h15, 0, 1, n);
    out_ready = 1; tick; out_ready = 0;
    gap;
    chk("t5b_no_overflow", 32'(c_ovf - base), 32'd0);
    chk("t5b_count_full", 32'(fifo_count), 32'd4);
    out_ready = 1;
    for (int i = 2; i <= 5; i++) begin
      chk("t5b_drain", 32'({out_valid, out_data}), 32'({1'b1, 8'h10 + 8'(i)}));
      tick;
    end
    out_ready = 0;
    gap;

    // reset mid-frame with entries queued and a pending prefix
    send_frame(8'h21, 0, 1, n); gap;
    send_frame(8'h22, 0, 1, n); gap;
    send_frame(8'hE0, 0, 1, n); gap;
    chk("t6_two_queued", 32'(fifo_count), 32'd2);
    partial(2, s);
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset = 0; tick; reset = 1;
    chk("t6_after_reset", 32'({out_valid, fifo_count, busy}), 32'd0);
    tick;
    out_ready = 1;
    send_frame(8'h33, 0, 1, n); tick;
    chk("t6_post_reset_frame", 32'({out_valid, out_extended, out_release, out_data}), 32'({3'b100, 8'h33}));
    gap;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_event_fifo.md
# ps2_rx_event_fifo

Parametrised PS/2 device-to-host receiver. Deserialises frames on `ps2_clk_posedge` strobes, checks odd parity, stop bit and inter-edge timeout, optionally folds 0xE0/0xF0 prefixes into key events, and buffers results in a FIFO with a valid/ready interface. Sits between the PS/2 clock-edge/synchroniser logic and game-input consumers. It replaces single-register capture, so back-to-back scan codes are not lost when the consumer is slow.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5..9.
- `FIFO_DEPTH`, 4: number of FIFO entries; a power of two, 2..16.
- `TIMEOUT_CYCLES`, 50000: maximum number of `clk` cycles allowed between bit edges inside a frame.
- `DECODE`, 1: 1 selects key-event mode, 0 selects raw-byte mode. `DECODE=1` requires `DATA_BITS=8`.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wait_for_incoming_data`  in  1  arms the receiver to wait for a start bit.
- `start_receiving_data`  in  1  start bit already consumed; go straight to data bits.
- `ps2_clk_posedge`  in  1  single-cycle strobe, one per PS/2 clock rising edge.
- `ps2_data`  in  1  synchronised PS/2 data line.
- `out_ready`  in  1  consumer accepts the FIFO head.
- `out_valid`  out  1  FIFO is not empty.
- `out_data`  out  DATA_BITS  code at the FIFO head.
- `out_extended`  out  1  head entry was preceded by 0xE0 (always 0 when `DECODE=0`).
- `out_release`  out  1  head entry was preceded by 0xF0 (always 0 when `DECODE=0`).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `busy`  out  1  receiver is not in IDLE.
- `parity_error`, `framing_error`, `timeout_error`, `overflow`  out  1 each  single-cycle error pulses.

## Operation
- Reset value of every output is 0: FIFO empty, FSM in IDLE, decoder flags cleared, pulse outputs low.
- FSM states and transitions:
  - IDLE: → WAIT_START if `wait_for_incoming_data`; otherwise → DATA if `start_receiving_data`. `wait_for_incoming_data` has priority.
  - WAIT_START: → DATA on a strobe with `ps2_data`=0. → IDLE if `wait_for_incoming_data` drops. A strobe with `ps2_data`=1 is ignored.
  - DATA: shift `ps2_data` into the MSB on each strobe (LSB-first line order). → PARITY on the strobe that captures bit `DATA_BITS-1`.
  - PARITY: sample the parity bit on a strobe, then → STOP.
  - STOP: sample the stop bit on a strobe, then → IDLE.
- Frame check at the STOP strobe, in priority order:
  - XOR of data and parity bits is 0 (odd parity failed): pulse `parity_error`, discard the frame.
  - Otherwise, stop bit = 0: pulse `framing_error`, discard the frame.
  - Otherwise: the frame is good and goes to the decoder.
- Timeout:
  - The counter clears on every strobe and in IDLE/WAIT_START, and counts while in DATA/PARITY/STOP.
  - When the count reaches `TIMEOUT_CYCLES-1`: → IDLE, pulse `timeout_error`, discard the partial frame.
- Decoder, `DECODE=1`:
  - Good byte 0xE0 sets `ext`; good byte 0xF0 sets `rel`; neither is pushed.
  - Any other good byte pushes {`ext`, `rel`, byte} and clears both flags.
  - Any error pulse also clears both flags.
- Decoder, `DECODE=0`: every good byte is pushed with both flags 0.
- FIFO:
  - A pop happens when `out_valid && out_ready`.
  - A push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - If neither holds, the entry is dropped, `overflow` pulses, and contents are unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Outputs are registered and show the head entry; they hold while `out_ready`=0.
- Reset mid-frame or with a non-empty FIFO: on the next edge, everything returns to reset values and in-flight data is lost.

## Timing
- Stop strobe in cycle N:
  - Error pulses are high in cycle N+1.
  - The decoder registers the good byte at the end of N+1.
  - The FIFO write occurs at the end of N+1; `out_valid`/`out_data` are valid from cycle N+2.
- Prefix bytes produce no output and no `out_valid` change.
- A pop in cycle M advances the head; the new head, or `out_valid`=0, appears in cycle M+1.
- `fifo_count` is unchanged by a simultaneous push and pop.
- `busy` is high in the cycle after leaving IDLE, and low in the cycle after returning to IDLE.
- The FSM accepts at most one transition per cycle. A strobe coinciding with timeout terminal count counts as a strobe: the counter clears and no timeout occurs.

## Test plan
- Reset, then `wait_for_incoming_data`=1, send frame 0x1C (parity 0, stop 1) with `out_ready`=1 → `out_valid` high 2 cycles after the stop strobe; `out_data`=0x1C, `out_extended`=0, `out_release`=0; `fifo_count` returns to 0.
- Send 0xE0, 0xF0, 0x75 → exactly one entry: 0x75, `out_extended`=1, `out_release`=1. Then send 0x75 → entry 0x75 with both flags 0.
- Send 0x1C with the parity bit flipped, then 0x1C with stop bit 0 → one `parity_error` pulse, then one `framing_error` pulse; FIFO stays empty.
- `TIMEOUT_CYCLES`=100: stop strobes after 3 data bits → `timeout_error` pulses 100 cycles after the last strobe, FSM in IDLE. A following full frame 0x29 is received correctly.
- `FIFO_DEPTH`=4, `out_ready`=0: send 5 codes 0x01..0x05 → `fifo_count`=4, `overflow` pulses once on 0x05. Draining yields 0x01..0x04 in order. Repeat with `out_ready`=1 timed so a pop coincides with the 5th push → no overflow.
- Assert `reset`=0 mid-frame with 2 entries queued → the next cycle shows `out_valid`=0, `fifo_count`=0, `busy`=0; the next full frame decodes correctly.
